// File: rtl/ula_multdiv.sv
`timescale 1ns/1ps
// ula_multdiv: iterative multiply/divide unit holding the architectural
// HI/LO registers.
//   op          : ALU control code, 4'b1100 starts a multiply, 4'b1101 a divide
//   start       : request, only taken while idle and not in the done cycle
//   is_unsigned : 1 = unsigned operands, 0 = two's-complement operands
//   a, b        : rs / rt operands, needed only on the accept edge
//   hi_we/lo_we : mthi / mtlo strobes writing wdata while idle
//   busy        : high while iterating
//   done        : one-cycle pulse once HI/LO hold the new result
//   div_zero    : pulses with done when the divisor was zero
//   hi, lo      : HI / LO register contents
// Multiply is shift-add on a 2*WIDTH accumulator, divide is restoring
// division. Both work on magnitudes and fix up the sign in the FIX state.
module ula_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mag_a, mag_b, orig_a, rem;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg_main, neg_rem, is_div, b_zero;

    logic                 accept, last_iter, fits;
    logic [WIDTH-1:0]     abs_a, abs_b, div_diff;
    logic [WIDTH:0]       mul_sum, rem_shift;
    logic [2*WIDTH-1:0]   product;

    // The done cycle is already IDLE, but a new request must wait one more cycle.
    assign accept    = (state == IDLE) && !done && start && (op == OP_MUL || op == OP_DIV);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state == MUL) || (state == DIV);

    always_comb begin
        abs_a     = (!is_unsigned && a[WIDTH-1]) ? -a : a;
        abs_b     = (!is_unsigned && b[WIDTH-1]) ? -b : b;
        // Add the multiplicand when the current multiplier bit (acc LSB) is set.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
        // Dividend bits shift out of the quotient half into the partial remainder.
        rem_shift = {rem, acc[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, mag_b});
        // When it fits the true difference is below mag_b, so WIDTH bits suffice.
        div_diff  = rem_shift[WIDTH-1:0] - mag_b;
        product   = neg_main ? -acc : acc;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (op == OP_MUL) ? MUL : DIV;
            MUL:     if (last_iter) state_next = FIX;
            DIV:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and the HI/LO write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            orig_a   <= '0;
            rem      <= '0;
            acc      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= (state == FIX);
            div_zero <= (state == FIX) && is_div && b_zero;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        cnt      <= '0;
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        orig_a   <= a;
                        rem      <= '0;
                        is_div   <= (op == OP_DIV);
                        b_zero   <= (b == '0);
                        neg_main <= !is_unsigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= !is_unsigned && a[WIDTH-1];
                        acc      <= {{WIDTH{1'b0}}, (op == OP_MUL) ? abs_b : abs_a};
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    if (!last_iter) cnt <= cnt + CW'(1);
                end
                DIV: begin
                    if (fits) begin
                        rem              <= div_diff;
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
                    end else begin
                        rem              <= rem_shift[WIDTH-1:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
                    end
                    if (!last_iter) cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= product;
                    end else if (b_zero) begin
                        lo <= {WIDTH{1'b1}};
                        hi <= orig_a;
                    end else begin
                        lo <= neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_rem  ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multdiv.sv
`timescale 1ns/1ps
// tb_ula_multdiv: directed and random checks of ula_multdiv against a
// plain-arithmetic reference model.
module tb_ula_multdiv;

    logic        clk = 1'b0;
    logic        rst_n, start, is_unsigned, hi_we, lo_we;
    logic [3:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    ula_multdiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .start(start),
        .is_unsigned(is_unsigned), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model written with ordinary 64-bit arithmetic.
    task automatic modelOp(input logic [3:0] o, input logic u, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] rh, output logic [31:0] rl, output logic dz);
        longint      sx, sy;
        logic [63:0] p, q, r;
        dz = 1'b0;
        if (u) begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        if (o == 4'b1100) begin
            p  = sx * sy;
            rh = p[63:32];
            rl = p[31:0];
        end else if (y == 32'd0) begin
            rl = 32'hFFFF_FFFF;
            rh = x;
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            rl = q[31:0];
            rh = r[31:0];
        end
    endtask

    // One full operation: accept, wait for done, compare, then confirm quiet.
    task automatic applyStimulus(input logic [3:0] o, input logic u, input logic [31:0] x, input logic [31:0] y,
                                 input bit poke_start, input bit poke_lo, input bit lo_at_start, input string tag);
        logic [31:0] mh, ml;
        logic        mdz;
        int          cycles, busy_cnt, extra;
        bit          seen;
        modelOp(o, u, x, y, mh, ml, mdz);
        @(negedge clk);
        op = o; is_unsigned = u; a = x; b = y; start = 1'b1;
        if (lo_at_start) begin
            lo_we = 1'b1;
            wdata = 32'h0F0F_1234;
        end
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom; is_unsigned = 1'($urandom);
        if (lo_at_start) begin
            checkOutput({tag, "_lo_wr_at_start"}, {32'b0, lo}, {32'b0, 32'h0F0F_1234});
            exp_lo = 32'h0F0F_1234;
        end
        busy_cnt = busy ? 1 : 0;
        cycles = 0;
        seen = 0;
        while (!seen && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (busy) busy_cnt++;
            if (cycles == 10) begin
                if (poke_start) begin
                    start = 1'b1; op = 4'b1101;
                end
                if (poke_lo) begin
                    lo_we = 1'b1; wdata = 32'h5555_5555;
                end
            end
            if (cycles == 11) begin
                start = 1'b0; lo_we = 1'b0;
                if (poke_lo) checkOutput({tag, "_lo_we_busy"}, {32'b0, lo}, {32'b0, exp_lo});
            end
            if (done) seen = 1;
        end
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        checkOutput({tag, "_hi"}, {32'b0, hi}, {32'b0, mh});
        checkOutput({tag, "_lo"}, {32'b0, lo}, {32'b0, ml});
        checkOutput({tag, "_div_zero"}, {63'b0, div_zero}, {63'b0, mdz});
        exp_hi = mh;
        exp_lo = ml;
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checkOutput({tag, "_extra_done"}, 64'(extra), 64'd0);
        checkOutput({tag, "_hi_hold"}, {32'b0, hi}, {32'b0, exp_hi});
    endtask

    initial begin
        int extra;
        logic [3:0]  ro;
        logic        ru;
        logic [31:0] rx, ry;

        rst_n = 1'b0; start = 1'b0; is_unsigned = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 4'b0; a = '0; b = '0; wdata = '0;
        #12;
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);
        checkOutput("reset_div_zero", {63'b0, div_zero}, 64'd0);
        checkOutput("reset_hi", {32'b0, hi}, 64'd0);
        checkOutput("reset_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(4'b1100, 1'b1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "mulu");
        checkOutput("mulu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        applyStimulus(4'b1100, 1'b0, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, "muls");
        checkOutput("muls_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus(4'b1101, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, "divs");
        checkOutput("divs_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(4'b1101, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, "divu");
        checkOutput("divu_const", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
        applyStimulus(4'b1101, 1'b0, 32'h1234_5678, 32'd0, 0, 0, 0, "div0");
        checkOutput("div0_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        applyStimulus(4'b1101, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "divovf");
        checkOutput("divovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        $display("[TB] start while busy, mtlo while busy, mtlo with start");
        applyStimulus(4'b1100, 1'b0, 32'h0001_2345, 32'hFFFF_0F00, 1, 0, 0, "busy_start");
        applyStimulus(4'b1101, 1'b1, 32'hCAFE_F00D, 32'd1234, 0, 1, 0, "busy_lo");
        applyStimulus(4'b1100, 1'b1, 32'h0000_1000, 32'h0000_0010, 0, 0, 1, "lo_start");

        $display("[TB] unsupported op");
        @(negedge clk);
        op = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("badop_busy", {63'b0, busy}, 64'd0);
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checkOutput("badop_quiet", 64'(extra), 64'd0);

        $display("[TB] mthi / mtlo");
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checkOutput("mthi", {32'b0, hi}, {32'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        checkOutput("preload", {hi, lo}, 64'hAAAA_AAAA_AAAA_AAAA);

        $display("[TB] reset during divide");
        @(negedge clk);
        op = 4'b1101; is_unsigned = 1'b1; a = 32'h9876_5432; b = 32'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        checkOutput("abort_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checkOutput("abort_no_done", 64'(extra), 64'd0);
        checkOutput("abort_hilo_after", {hi, lo}, 64'd0);

        $display("[TB] random operations");
        for (int i = 0; i < 24; i++) begin
            ro = ($urandom_range(0, 1) == 1) ? 4'b1101 : 4'b1100;
            ru = 1'($urandom);
            rx = $urandom;
            case ($urandom_range(0, 5))
                0:       ry = 32'd0;
                1:       ry = $urandom_range(1, 15);
                2:       ry = 32'hFFFF_FFFF;
                default: ry = $urandom;
            endcase
            applyStimulus(ro, ru, rx, ry, 0, 0, 0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
